// File: rtl/hazard_pkg.sv
// Shared definitions for the ID-stage hazard scoreboard: stall-cause encodings
// and the default producer latencies of the 5-stage core.
package hazard_pkg;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_FWD  = 2'd1,
        CAUSE_WB   = 2'd2
    } stall_cause_e;

    localparam int LAT_ALU      = 0;
    localparam int LAT_LOAD_FWD = 1;
    localparam int LAT_WB       = 2;

    localparam logic [4:0] ECALL_SRC = 5'd17;
    localparam int         NUM_REGS  = 32;

endpackage

// File: rtl/hazard_reg_counter.sv
// Per-register countdown: load wins over the free-running decrement, and the
// busy flag says the pending value is not yet available on this path.
module hazard_reg_counter #(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    output logic             busy
);

    logic [LAT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every counter
    // samples the pre-edge values of its neighbours, regardless of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - LAT_W'(1);
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: per-register forward/writeback countdowns, stall
// decision and cause, and a saturating stall-cycle counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter  int NUM_SRC = 2,
    parameter  int MAX_LAT = 4,
    parameter  int CNT_W   = 32,
    localparam int LAT_W   = $clog2(MAX_LAT + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [NUM_SRC*5-1:0] id_src,
    input  logic [NUM_SRC-1:0]   id_src_use,
    input  logic [NUM_SRC-1:0]   id_src_nofwd,
    input  logic [4:0]           id_rd,
    input  logic                 id_reg_write,
    input  logic [LAT_W-1:0]     id_fwd_lat,
    input  logic [LAT_W-1:0]     id_wb_lat,
    input  logic                 flush,
    output logic                 is_stall,
    output logic [1:0]           stall_cause,
    output logic [CNT_W-1:0]     stall_count
);

    localparam logic [LAT_W-1:0] MAX_LAT_V = LAT_W'(MAX_LAT);

    logic                 issue;
    logic                 load_en;
    logic [LAT_W-1:0]     fwd_load_val;
    logic [LAT_W-1:0]     wb_load_val;
    logic [NUM_REGS-1:0]  fwd_busy;
    logic [NUM_REGS-1:0]  wb_busy;
    logic [NUM_SRC-1:0]   fwd_hit;
    logic [NUM_SRC-1:0]   wb_hit;

    assign fwd_load_val = (id_fwd_lat > MAX_LAT_V) ? MAX_LAT_V : id_fwd_lat;
    assign wb_load_val  = (id_wb_lat  > MAX_LAT_V) ? MAX_LAT_V : id_wb_lat;

    assign issue   = id_valid & ~is_stall & ~flush;
    assign load_en = issue & id_reg_write & (id_rd != 5'd0);

    // x0 is hardwired zero, so it never holds a pending producer.
    assign fwd_busy[0] = 1'b0;
    assign wb_busy[0]  = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
        logic load_r;
        assign load_r = load_en & (id_rd == 5'(r));

        hazard_reg_counter #(.LAT_W(LAT_W)) u_fwd (
            .clk      (clk),
            .reset    (reset),
            .load     (load_r),
            .load_val (fwd_load_val),
            .busy     (fwd_busy[r])
        );

        hazard_reg_counter #(.LAT_W(LAT_W)) u_wb (
            .clk      (clk),
            .reset    (reset),
            .load     (load_r),
            .load_val (wb_load_val),
            .busy     (wb_busy[r])
        );
    end

    // NOTE: combinational outputs get a default before any branch so no path
    // leaves them unassigned and infers a latch.
    always_comb begin
        fwd_hit = '0;
        wb_hit  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (id_valid && id_src_use[k] && (id_src[5*k +: 5] != 5'd0)) begin
                if (id_src_nofwd[k]) begin
                    wb_hit[k] = wb_busy[id_src[5*k +: 5]];
                end else begin
                    fwd_hit[k] = fwd_busy[id_src[5*k +: 5]];
                end
            end
        end
    end

    assign is_stall = (|fwd_hit) | (|wb_hit);

    // Writeback waits are longer, so they take priority in the reported cause.
    always_comb begin
        stall_cause = CAUSE_NONE;
        if (|wb_hit) begin
            stall_cause = CAUSE_WB;
        end else if (|fwd_hit) begin
            stall_cause = CAUSE_FWD;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
        end else if (is_stall && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a per-cycle vector table followed by
// hand-written reset-mid-stall and stall-counter saturation sequences.
module tb_hazard_scoreboard;

    localparam int NUM_SRC = 2;
    localparam int MAX_LAT = 4;
    localparam int CNT_W   = 4;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [9:0]  id_src;
    logic [1:0]  id_src_use;
    logic [1:0]  id_src_nofwd;
    logic [4:0]  id_rd;
    logic        id_reg_write;
    logic [2:0]  id_fwd_lat;
    logic [2:0]  id_wb_lat;
    logic        flush;
    logic        is_stall;
    logic [1:0]  stall_cause;
    logic [3:0]  stall_count;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_scoreboard #(
        .NUM_SRC (NUM_SRC),
        .MAX_LAT (MAX_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_src       (id_src),
        .id_src_use   (id_src_use),
        .id_src_nofwd (id_src_nofwd),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_fwd_lat   (id_fwd_lat),
        .id_wb_lat    (id_wb_lat),
        .flush        (flush),
        .is_stall     (is_stall),
        .stall_cause  (stall_cause),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       valid;
        logic [4:0] s0;
        logic [4:0] s1;
        logic [1:0] src_use;
        logic [1:0] nofwd;
        logic [4:0] rd;
        logic       we;
        logic [2:0] fl;
        logic [2:0] wl;
        logic       fsh;
        logic       exp_stall;
        logic [1:0] exp_cause;
        logic [3:0] exp_count;
    } vec_t;

    function automatic vec_t mk(input logic rst_n, input logic valid,
                                input logic [4:0] s0, input logic [4:0] s1,
                                input logic [1:0] src_use, input logic [1:0] nofwd,
                                input logic [4:0] rd, input logic we,
                                input logic [2:0] fl, input logic [2:0] wl,
                                input logic fsh, input logic exp_stall,
                                input logic [1:0] exp_cause, input logic [3:0] exp_count);
        vec_t v;
        v.rst_n = rst_n;  v.valid = valid;  v.s0 = s0;  v.s1 = s1;
        v.src_use = src_use;  v.nofwd = nofwd;  v.rd = rd;  v.we = we;
        v.fl = fl;  v.wl = wl;  v.fsh = fsh;
        v.exp_stall = exp_stall;  v.exp_cause = exp_cause;  v.exp_count = exp_count;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic drive(input vec_t v);
        reset        = v.rst_n;
        id_valid     = v.valid;
        id_src       = {v.s1, v.s0};
        id_src_use   = v.src_use;
        id_src_nofwd = v.nofwd;
        id_rd        = v.rd;
        id_reg_write = v.we;
        id_fwd_lat   = v.fl;
        id_wb_lat    = v.wl;
        flush        = v.fsh;
    endtask

    // Apply one cycle of inputs just after the rising edge, compare at the
    // falling edge, then move to just past the next rising edge.
    task automatic step(input vec_t v, input string tag);
        drive(v);
        @(negedge clk);
        check({tag, " is_stall"},    32'(is_stall),    32'(v.exp_stall));
        check({tag, " stall_cause"}, 32'(stall_cause), 32'(v.exp_cause));
        check({tag, " stall_count"}, 32'(stall_count), 32'(v.exp_count));
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];
    vec_t idle;
    vec_t rst_row;
    vec_t v;
    int   model_cnt;

    initial begin
        idle    = mk(1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_row = mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(rst_row);
        @(posedge clk);
        #1;

        //                  rst v  s0  s1 use    nofwd  rd we fl wl fsh  stl cause cnt
        // load-use: lw x5, then add x6,x5,x1 stalls one cycle
        tbl.push_back(mk(0, 0,  0,  0, 2'b00, 2'b00,  0, 0, 0, 0, 0,   0, 0, 0));
        tbl.push_back(mk(1, 1,  1,  0, 2'b01, 2'b00,  5, 1, 1, 2, 0,   0, 0, 0));
        tbl.push_back(mk(1, 1,  5,  1, 2'b11, 2'b00,  6, 1, 0, 2, 0,   1, 1, 0));
        tbl.push_back(mk(1, 1,  5,  1, 2'b11, 2'b00,  6, 1, 0, 2, 0,   0, 0, 1));
        tbl.push_back(mk(1, 0,  0,  0, 2'b00, 2'b00,  0, 0, 0, 0, 0,   0, 0, 1));
        // ecall waits two cycles for x17 writeback
        tbl.push_back(mk(0, 0,  0,  0, 2'b00, 2'b00,  0, 0, 0, 0, 0,   0, 0, 0));
        tbl.push_back(mk(1, 1,  0,  0, 2'b01, 2'b00, 17, 1, 0, 2, 0,   0, 0, 0));
        tbl.push_back(mk(1, 1, 17,  0, 2'b01, 2'b01,  0, 0, 0, 0, 0,   1, 2, 0));
        tbl.push_back(mk(1, 1, 17,  0, 2'b01, 2'b01,  0, 0, 0, 0, 0,   1, 2, 1));
        tbl.push_back(mk(1, 1, 17,  0, 2'b01, 2'b01,  0, 0, 0, 0, 0,   0, 0, 2));
        // x0 destination/source and unused sources never stall
        tbl.push_back(mk(0, 0,  0,  0, 2'b00, 2'b00,  0, 0, 0, 0, 0,   0, 0, 0));
        tbl.push_back(mk(1, 1,  0,  0, 2'b01, 2'b00,  0, 1, 1, 2, 0,   0, 0, 0));
        tbl.push_back(mk(1, 1,  0,  0, 2'b11, 2'b00,  6, 1, 0, 2, 0,   0, 0, 0));
        tbl.push_back(mk(1, 1,  0,  0, 2'b01, 2'b00,  5, 1, 1, 2, 0,   0, 0, 0));
        tbl.push_back(mk(1, 1,  5,  5, 2'b00, 2'b00,  0, 0, 0, 0, 0,   0, 0, 0));
        tbl.push_back(mk(1, 0,  0,  0, 2'b00, 2'b00,  0, 0, 0, 0, 0,   0, 0, 0));
        // slow producer to x5 overwritten by an ALU op: consumer does not stall
        tbl.push_back(mk(1, 1,  0,  0, 2'b01, 2'b00,  5, 1, 3, 3, 0,   0, 0, 0));
        tbl.push_back(mk(1, 1,  0,  0, 2'b01, 2'b00,  5, 1, 0, 2, 0,   0, 0, 0));
        tbl.push_back(mk(1, 1,  5,  0, 2'b01, 2'b00,  0, 0, 0, 0, 0,   0, 0, 0));
        tbl.push_back(mk(1, 0,  0,  0, 2'b00, 2'b00,  0, 0, 0, 0, 0,   0, 0, 0));
        // flushed producer creates no entry
        tbl.push_back(mk(1, 1,  0,  0, 2'b01, 2'b00,  9, 1, 3, 3, 1,   0, 0, 0));
        tbl.push_back(mk(1, 1,  9,  0, 2'b01, 2'b00,  0, 0, 0, 0, 0,   0, 0, 0));
        // flush of a stalled consumer leaves the issued producer's entry alone
        tbl.push_back(mk(1, 1,  0,  0, 2'b01, 2'b00, 10, 1, 2, 2, 0,   0, 0, 0));
        tbl.push_back(mk(1, 1, 10,  0, 2'b01, 2'b00,  0, 0, 0, 0, 1,   1, 1, 0));
        tbl.push_back(mk(1, 1, 10,  0, 2'b01, 2'b00,  0, 0, 0, 0, 0,   1, 1, 1));
        tbl.push_back(mk(1, 1, 10,  0, 2'b01, 2'b00,  0, 0, 0, 0, 0,   0, 0, 2));
        // fwd latency 7 clamps to 4: exactly four stall cycles on source 1
        tbl.push_back(mk(0, 0,  0,  0, 2'b00, 2'b00,  0, 0, 0, 0, 0,   0, 0, 0));
        tbl.push_back(mk(1, 1,  0,  0, 2'b01, 2'b00,  7, 1, 7, 7, 0,   0, 0, 0));
        tbl.push_back(mk(1, 1,  0,  7, 2'b10, 2'b00,  0, 0, 0, 0, 0,   1, 1, 0));
        tbl.push_back(mk(1, 1,  0,  7, 2'b10, 2'b00,  0, 0, 0, 0, 0,   1, 1, 1));
        tbl.push_back(mk(1, 1,  0,  7, 2'b10, 2'b00,  0, 0, 0, 0, 0,   1, 1, 2));
        tbl.push_back(mk(1, 1,  0,  7, 2'b10, 2'b00,  0, 0, 0, 0, 0,   1, 1, 3));
        tbl.push_back(mk(1, 1,  0,  7, 2'b10, 2'b00,  0, 0, 0, 0, 0,   0, 0, 4));
        tbl.push_back(mk(1, 0,  0,  0, 2'b00, 2'b00,  0, 0, 0, 0, 0,   0, 0, 4));

        foreach (tbl[i]) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset asserted mid-stall clears state at once; the consumer then proceeds.
        step(rst_row, "mrst reset");
        step(mk(1, 1, 0, 0, 2'b01, 2'b00, 7, 1, 3, 3, 0, 0, 0, 0), "mrst issue");
        step(mk(1, 1, 7, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0), "mrst stall0");
        v = mk(1, 1, 7, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 1, 1, 1);
        drive(v);
        @(negedge clk);
        check("mrst stall1 is_stall", 32'(is_stall), 32'd1);
        check("mrst stall1 count", 32'(stall_count), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("mrst held is_stall", 32'(is_stall), 32'd0);
        check("mrst held cause", 32'(stall_cause), 32'd0);
        check("mrst held count", 32'(stall_count), 32'd0);
        @(posedge clk);
        #1;
        v.exp_stall = 1'b0;
        v.exp_cause = 2'd0;
        v.exp_count = 4'd0;
        step(v, "mrst release");

        // Self-dependent producer on x8 with latency 4: stall 4, issue 1, repeat.
        step(rst_row, "sat reset");
        v = mk(1, 1, 8, 0, 2'b01, 2'b00, 8, 1, 4, 4, 0, 0, 0, 0);
        model_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            v.exp_stall = ((i % 5) != 0);
            v.exp_cause = v.exp_stall ? 2'd1 : 2'd0;
            v.exp_count = 4'(model_cnt);
            step(v, $sformatf("sat%0d", i));
            if (v.exp_stall && model_cnt < 15) model_cnt++;
        end
        drive(idle);
        @(negedge clk);
        check("sat final count", 32'(stall_count), 32'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
